motion_sequencer: RTL and testbench
===================================

# motion_sequencer

Move-level controller that sits above the stepper driver and commands it. It accepts relative move commands over a valid/ready handshake. It drives the driver's speed, direction and run-enable inputs with a trapezoidal (or triangular) speed profile, and counts the driver's step pulses to track remaining steps and absolute position. Completion is reported with a one-cycle done pulse.

## Interface
- RAMP_TICK_CYCLES, 250_000: clock cycles between speed updates (10 ms at 25 MHz).
- MIN_SPEED, 10: start/stop speed in steps/s, unsigned, at least 1.
- clock  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high exactly when in IDLE.
- cmd_steps  in  24  signed relative move in step pulses; sign selects direction.
- cmd_max_speed  in  10  cruise speed in steps/s.
- cmd_accel  in  10  speed increment/decrement per ramp tick.
- abort  in  1  level; requests a controlled stop.
- step_in  in  1  driver step output; synchronous to clock, high for at least 2 cycles.
- speed  out  10  to driver speed input.
- dir_out  out  1  to driver dir_in; 1 = positive/clockwise.
- run_en  out  1  to driver run_en.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  registered; set on an aborted move, cleared at the next command accept.
- position  out  32  signed absolute step count; wraps two's complement.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, STOP.
- Accept: cmd_valid & cmd_ready. On accept:
  - remaining = |cmd_steps| (24-bit unsigned; -2^23 is legal).
  - dir_out = ~cmd_steps[23].
  - vmax = max(cmd_max_speed, MIN_SPEED).
  - acc = max(cmd_accel, 1).
  - ramp_steps = 0; tick counter = 0; abort latch cleared; aborted cleared.
  - Next state: speed = min(MIN_SPEED, vmax) and ACCEL if remaining ≠ 0; otherwise STOP.
- Step edge: step_in & ~step_d, where step_d is step_in registered. In ACCEL, CRUISE and DECEL, each edge does remaining−1, position ±1 (per dir_out), and ramp_steps+1 in ACCEL only. Edges in IDLE or STOP are ignored.
- Ramp tick: asserted when the counter reaches RAMP_TICK_CYCLES−1, then the counter wraps to 0. The counter runs only in ACCEL, CRUISE and DECEL.
- ACCEL:
  - On tick, speed = min(speed+acc, vmax), computed 11-bit wide with no overflow.
  - Go to CRUISE when speed == vmax.
- CRUISE: speed held.
- DECEL entry: from ACCEL or CRUISE when remaining ≤ ramp_steps, or when the abort latch is set. This gives a triangular profile on short moves.
- DECEL: on tick, speed = max(speed−acc, MIN_SPEED), saturating with no underflow.
- STOP entry, from any running state, with highest priority:
  - remaining == 0.
  - In DECEL with abort latched: speed == MIN_SPEED and a step edge occurs. That edge is counted.
- STOP lasts one cycle: done=1, run_en=0, speed=0; aborted=1 if the abort latch is set. Then IDLE.
- abort sampled high in ACCEL, CRUISE or DECEL sets the latch. It is ignored in IDLE and STOP.
- run_en = 1 in ACCEL, CRUISE and DECEL only. speed = 0 in IDLE and STOP.
- Commands offered while busy are not accepted; cmd_ready is low.

## Timing
- Reset values (async): state IDLE, speed 0, dir_out 0, run_en 0, busy 0, done 0, aborted 0, position 0, remaining 0, step_d 0. cmd_ready is 1 during and after reset.
- Accept cycle N:
  - busy, run_en and initial speed are valid at N+1.
  - For a zero-step command, STOP is at N+1 (done=1, run_en never asserted) and IDLE/cmd_ready at N+2.
- Final step edge seen at cycle M: STOP and done at M+1, run_en low at M+1, IDLE/cmd_ready at M+2. This is well inside the driver's 100-cycle minimum low phase, so no extra step is issued.
- Priority when events coincide in one cycle: STOP condition > DECEL entry > tick update > CRUISE entry. An edge and a tick in the same cycle are both applied.
- Reset mid-move forces run_en to 0 immediately (async) and position to 0.

## Test plan
- Reset: assert reset_n=0 mid-cruise → run_en, speed, busy, done drop at once; position=0; cmd_ready=1.
- cmd_steps=0 accepted at N → done=1 only at N+1, run_en never 1, position unchanged, cmd_ready=1 at N+2.
- RAMP_TICK_CYCLES=100, step_in 2-cycle pulses every 20 cycles, cmd_steps=+1000, max=200, accel=50:
  - speed goes 10, 60, 110, 160, 200, then CRUISE.
  - DECEL starts when remaining ≤ ramp_steps.
  - Exactly 1000 edges counted; position=1000; one done pulse; speed returns to 0.
- cmd_steps=−40, max=1000, accel=5: never reaches CRUISE (triangle profile); dir_out=0; position=−40; aborted=0.
- abort pulsed in CRUISE of a +100000 move:
  - DECEL follows the next cycle; speed saturates at 10.
  - STOP occurs at the first edge at MIN_SPEED; aborted=1; position equals the edges counted.
- cmd_valid held high while busy with different payload → not accepted (cmd_ready=0); after done, accepted once in IDLE; aborted cleared on that accept.

Source files
------------

// File: rtl/motion_sequencer.sv
// Move-level stepper controller: accepts relative moves, drives a trapezoidal speed profile
// and counts driver step edges to track remaining steps and absolute position.
module motion_sequencer #(
    parameter int RAMP_TICK_CYCLES = 250_000,
    parameter int MIN_SPEED        = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [23:0]        cmd_steps,
    input  logic [9:0]         cmd_max_speed,
    input  logic [9:0]         cmd_accel,
    input  logic               abort,
    input  logic               step_in,
    output logic [9:0]         speed,
    output logic               dir_out,
    output logic               run_en,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic signed [31:0] position
);
    localparam int            TW        = (RAMP_TICK_CYCLES > 1) ? $clog2(RAMP_TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_TICK_CYCLES - 1);
    localparam logic [9:0]    MIN_SPD   = 10'(MIN_SPEED);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, STOP} state_t;
    state_t state, next_state;

    logic [23:0]   remaining, ramp_steps, rem_nxt, ramp_nxt, mag;
    logic [9:0]    speed_q, vmax, acc, spd_up_sat, spd_dn_sat;
    logic [10:0]   spd_up, spd_floor;
    logic [TW-1:0] tick_cnt;
    logic          step_d, abort_lat;
    logic          running, accept, step_edge, tick, stop_cond, decel_entry;

    assign running   = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
    assign accept    = cmd_valid && (state == IDLE);
    assign step_edge = running && step_in && !step_d;
    assign tick      = running && (tick_cnt == TICK_LAST);
    assign mag       = cmd_steps[23] ? (~cmd_steps + 24'd1) : cmd_steps;

    // Decisions use the post-edge counts so the final edge stops the move in the next cycle
    assign rem_nxt   = remaining - {23'd0, step_edge};
    assign ramp_nxt  = ramp_steps + {23'd0, step_edge && (state == ACCEL)};

    assign stop_cond = running && ((remaining == 24'd0) ||
                                   (step_edge && remaining == 24'd1) ||
                                   (state == DECEL && abort_lat && speed_q == MIN_SPD && step_edge));
    assign decel_entry = ((state == ACCEL) || (state == CRUISE)) &&
                         ((rem_nxt <= ramp_nxt) || abort_lat);

    assign spd_up     = {1'b0, speed_q} + {1'b0, acc};
    assign spd_up_sat = (spd_up > {1'b0, vmax}) ? vmax : spd_up[9:0];
    assign spd_floor  = {1'b0, acc} + {1'b0, MIN_SPD};
    assign spd_dn_sat = ({1'b0, speed_q} < spd_floor) ? MIN_SPD : (speed_q - acc);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (cmd_valid) next_state = (cmd_steps == 24'd0) ? STOP : ACCEL;
            ACCEL, CRUISE, DECEL: begin
                if (stop_cond)                              next_state = STOP;
                else if (decel_entry)                       next_state = DECEL;
                else if (state == ACCEL && speed_q == vmax) next_state = CRUISE;
            end
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        run_en    = running;
        done      = (state == STOP);
        speed     = running ? speed_q : 10'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_d     <= 1'b0;
            remaining  <= '0;
            ramp_steps <= '0;
            tick_cnt   <= '0;
            speed_q    <= '0;
            vmax       <= '0;
            acc        <= '0;
            dir_out    <= 1'b0;
            abort_lat  <= 1'b0;
            aborted    <= 1'b0;
            position   <= '0;
        end else begin
            step_d <= step_in;
            if (accept) begin
                remaining  <= mag;
                dir_out    <= ~cmd_steps[23];
                vmax       <= (cmd_max_speed < MIN_SPD) ? MIN_SPD : cmd_max_speed;
                acc        <= (cmd_accel == 10'd0) ? 10'd1 : cmd_accel;
                ramp_steps <= '0;
                tick_cnt   <= '0;
                abort_lat  <= 1'b0;
                aborted    <= 1'b0;
                speed_q    <= MIN_SPD;
            end else if (running) begin
                tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
                remaining  <= rem_nxt;
                ramp_steps <= ramp_nxt;
                if (step_edge) position <= dir_out ? position + 32'sd1 : position - 32'sd1;
                if (abort) abort_lat <= 1'b1;
                // A tick coinciding with DECEL entry is dropped; DECEL takes over from the next tick
                if (stop_cond) begin
                    speed_q <= '0;
                    aborted <= abort_lat | abort;
                end else if (!decel_entry && tick) begin
                    if (state == ACCEL)      speed_q <= spd_up_sat;
                    else if (state == DECEL) speed_q <= spd_dn_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: a step-pulse driver model plus a move-level reference
// (edge counts, ramp sequence, position sum) checked over directed and random moves.
module tb_motion_sequencer;
    localparam int RTC  = 100;
    localparam int MINS = 10;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, abort = 1'b0, step_in = 1'b0;
    logic [23:0] cmd_steps = '0;
    logic [9:0]  cmd_max_speed = '0, cmd_accel = '0;
    logic        cmd_ready, dir_out, run_en, busy, done, aborted;
    logic [9:0]  speed;
    logic signed [31:0] position;

    motion_sequencer #(.RAMP_TICK_CYCLES(RTC), .MIN_SPEED(MINS)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_max_speed(cmd_max_speed), .cmd_accel(cmd_accel),
        .abort(abort), .step_in(step_in), .speed(speed), .dir_out(dir_out), .run_en(run_en),
        .busy(busy), .done(done), .aborted(aborted), .position(position)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Driver model: 2-cycle step pulses every `period` cycles while run_en is high
    int period = 20, ph = 0;
    initial forever begin
        @(negedge clock);
        if (run_en) begin
            ph      = (ph + 1 >= period) ? 0 : ph + 1;
            step_in = (ph >= period - 2);
        end else if (step_in && ph == period - 2) begin
            ph = period - 1;
        end else begin
            ph      = 0;
            step_in = 1'b0;
        end
    end

    int acc_cnt = 0;
    initial forever begin
        @(posedge clock);
        if (cmd_valid && cmd_ready) acc_cnt++;
    end

    int sample = 0, rises = 0, last_rise = -10, done_cnt = 0, done_sample = -1;
    int first_dec = -1, accel_rises = -1, peak = 0, last_spd = 0, cur_vmax = 0;
    int spd_q[$];
    logic step_prev = 1'b0;
    initial forever begin
        @(posedge clock); #1;
        sample++;
        if (step_in && !step_prev) begin rises++; last_rise = sample; end
        step_prev = step_in;
        if (done) begin done_cnt++; done_sample = sample; end
        if (run_en) begin
            if (spd_q.size() == 0 || int'(speed) != spd_q[$]) begin
                if (spd_q.size() != 0 && int'(speed) < spd_q[$] && first_dec < 0) first_dec = rises;
                spd_q.push_back(int'(speed));
            end
            if (int'(speed) == cur_vmax && accel_rises < 0) accel_rises = rises;
            if (int'(speed) > peak) peak = int'(speed);
            last_spd = int'(speed);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int d0 = 0;
    longint exp_pos = 0;

    task automatic clear_move(input int mx);
        rises = 0; spd_q.delete(); first_dec = -1; accel_rises = -1; peak = 0; last_spd = 0;
        cur_vmax = (mx < MINS) ? MINS : mx;
    endtask

    // Returns at the sample one cycle after the accept edge
    task automatic send(input int steps, input int mx, input int ac);
        int n = 0;
        clear_move(mx);
        @(negedge clock);
        cmd_steps = 24'(steps); cmd_max_speed = 10'(mx); cmd_accel = 10'(ac); cmd_valid = 1'b1;
        while (!cmd_ready && n < 1000) begin @(negedge clock); n++; end
        if (!cmd_ready) chk("send_ready_timeout", 0, 1);
        d0 = done_cnt;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(posedge clock); #2; n++; end
        if (done_cnt == d0) chk(tag, 0, 1);
    endtask

    task automatic wait_speed(input int v, input int budget);
        int n = 0;
        while (int'(speed) != v && n < budget) begin @(posedge clock); #2; n++; end
        if (int'(speed) != v) chk("wait_speed_timeout", speed, v);
    endtask

    initial begin
        int v, idx, rem_dec, a0, st, mx, ac;
        // Reset values
        #12;
        chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_run_en", run_en, 0);
        chk("rst_speed", speed, 0); chk("rst_done", done, 0); chk("rst_aborted", aborted, 0);
        chk("rst_pos", position, 0); chk("rst_dir", dir_out, 0);
        @(negedge clock); reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Zero-step move: STOP at N+1, IDLE at N+2
        send(0, 100, 10);
        chk("zero_done_n1", done, 1); chk("zero_run_en_n1", run_en, 0); chk("zero_ready_n1", cmd_ready, 0);
        @(posedge clock); #1;
        chk("zero_done_n2", done, 0); chk("zero_ready_n2", cmd_ready, 1); chk("zero_pos", position, 0);
        chk("zero_never_ran", peak, 0);

        // Trapezoid: +1000, vmax 200, accel 50
        period = 20;
        send(1000, 200, 50);
        chk("t_run_en_n1", run_en, 1); chk("t_busy_n1", busy, 1);
        chk("t_speed_n1", speed, MINS); chk("t_dir_n1", dir_out, 1);
        wait_done(30000, "t_done_timeout");
        exp_pos += 1000;
        chk("t_rises", rises, 1000); chk("t_pos", $signed(position), exp_pos);
        chk("t_done_at_edge", done_sample, last_rise);
        chk("t_stop_speed", speed, 0); chk("t_stop_run_en", run_en, 0);
        v = MINS; idx = 0;
        while (1) begin
            if (idx < spd_q.size()) chk("t_ramp_seq", spd_q[idx], v);
            else chk("t_ramp_seq_short", spd_q.size(), idx + 1);
            if (v == cur_vmax) break;
            v = (v + 50 > cur_vmax) ? cur_vmax : v + 50;
            idx++;
        end
        rem_dec = 1000 - first_dec;
        chk("t_decel_window", (first_dec >= 0 && rem_dec <= accel_rises + 1 && rem_dec + 7 >= accel_rises), 1);
        chk("t_end_speed_min", last_spd, MINS);
        @(posedge clock); #2;
        chk("t_ready_after", cmd_ready, 1);
        repeat (3) @(posedge clock); #2;
        chk("t_one_done", done_cnt - d0, 1);

        // Triangle: -40, vmax 1000, accel 5
        send(-40, 1000, 5);
        chk("tri_dir", dir_out, 0);
        wait_done(5000, "tri_done_timeout");
        exp_pos -= 40;
        chk("tri_rises", rises, 40); chk("tri_pos", $signed(position), exp_pos);
        chk("tri_no_cruise", peak < 1000, 1); chk("tri_aborted", aborted, 0);

        // Reset mid-cruise
        send(1000, 200, 50);
        wait_speed(200, 2000);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_run_en", run_en, 0); chk("mid_rst_speed", speed, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_pos", position, 0); chk("mid_rst_ready", cmd_ready, 1);
        exp_pos = 0;
        @(negedge clock); reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Abort during cruise of a long move
        send(100000, 200, 50);
        wait_speed(200, 2000);
        repeat (30) @(posedge clock);
        @(negedge clock); abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        wait_done(5000, "abort_done_timeout");
        exp_pos += rises;
        chk("abort_flag", aborted, 1); chk("abort_min_speed", last_spd, MINS);
        chk("abort_pos", $signed(position), exp_pos); chk("abort_stop_at_edge", done_sample, last_rise);
        chk("abort_short", rises < 100000, 1);
        repeat (2) @(posedge clock); #2;

        // Command held while busy: accepted once only after the move completes
        a0 = acc_cnt;
        send(30, 100, 20);
        chk("hold_aborted_cleared", aborted, 0);
        cmd_steps = 24'd7; cmd_max_speed = 10'd50; cmd_accel = 10'd9; cmd_valid = 1'b1;
        repeat (5) @(posedge clock); #1;
        chk("hold_not_ready", cmd_ready, 0);
        wait_done(3000, "hold_done_timeout");
        exp_pos += 30;
        chk("hold_first_accepts", acc_cnt - a0, 1);
        st = 0;
        while (acc_cnt - a0 < 2 && st < 10) begin @(posedge clock); #2; st++; end
        cmd_valid = 1'b0;
        clear_move(50);
        d0 = done_cnt;
        wait_done(3000, "hold2_done_timeout");
        exp_pos += 7;
        chk("hold2_rises", rises, 7); chk("hold2_pos", $signed(position), exp_pos);
        repeat (3) @(posedge clock); #2;
        chk("hold_accept_once", acc_cnt - a0, 2);

        // Random moves
        for (int k = 0; k < 6; k++) begin
            st = int'($urandom_range(0, 120)) - 60;
            mx = int'($urandom_range(0, 300));
            ac = int'($urandom_range(0, 80));
            period = int'($urandom_range(4, 12));
            send(st, mx, ac);
            wait_done(((st < 0 ? -st : st) + 4) * period + 2000, "rnd_done_timeout");
            exp_pos += st;
            chk("rnd_rises", rises, (st < 0) ? -st : st);
            chk("rnd_pos", $signed(position), exp_pos);
            chk("rnd_aborted", aborted, 0);
            repeat (2) @(posedge clock); #2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
